// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helper.
package aes_pkg;
  localparam int NUM_BYTES = 16;

  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } fsm_t;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
endpackage

// File: rtl/aes_sbox_lut.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox_lut
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Inverse computed as x^254 = x^2 * x^4 * ... * x^128 (0 maps to 0), then affine + 0x63.
  always_comb begin
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = din;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    dout = inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  end

endmodule

// File: rtl/aes_subbytes_serial.sv
// Serial AES SubBytes: substitutes BYTES_PER_CYCLE bytes per cycle in a held state register.
module aes_subbytes_serial
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear,
  input  logic   in_valid,
  output logic   in_ready,
  input  state_t in_state,
  output logic   out_valid,
  input  logic   out_ready,
  output state_t out_state,
  output logic   busy
);

  localparam int K  = NUM_BYTES / BYTES_PER_CYCLE;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
      BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bpc
    $error("aes_subbytes_serial: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  fsm_t    fsm_q, fsm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t  st_q, st_d;

  // Byte i of the AES state lives at packed index NUM_BYTES-1-i.
  logic [NUM_BYTES-1:0][7:0]       st_b;
  logic [BYTES_PER_CYCLE-1:0][3:0] lane_idx;
  logic [BYTES_PER_CYCLE-1:0][7:0] lut_in;
  logic [BYTES_PER_CYCLE-1:0][7:0] lut_out;
  logic                            last_grp;

  assign st_b     = st_q;
  assign last_grp = (cnt_q == CW'(K - 1));

  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
    assign lane_idx[j] = 4'(NUM_BYTES - 1 - (int'(cnt_q) * BYTES_PER_CYCLE + j));
    assign lut_in[j]   = st_b[lane_idx[j]];
    aes_sbox_lut u_sbox (.din(lut_in[j]), .dout(lut_out[j]));
  end

  // State, counter and FSM registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= ST_IDLE;
      cnt_q <= '0;
      st_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      st_q  <= st_d;
    end
  end

  // Next-state: latch on input handshake, substitute one group per RUN cycle; clear overrides all.
  always_comb begin
    logic [NUM_BYTES-1:0][7:0] wr_b;
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    st_d  = st_q;
    wr_b  = st_b;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          st_d  = in_state;
          cnt_d = '0;
          fsm_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int j = 0; j < BYTES_PER_CYCLE; j++) wr_b[lane_idx[j]] = lut_out[j];
        st_d = wr_b;
        if (last_grp) begin
          cnt_d = '0;
          fsm_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
    if (clear) begin
      fsm_d = ST_IDLE;
      cnt_d = '0;
      st_d  = st_q;
    end
  end

  assign in_ready  = (fsm_q == ST_IDLE);
  assign out_valid = (fsm_q == ST_DONE);
  assign busy      = (fsm_q != ST_IDLE);
  assign out_state = st_q;

endmodule
